layer_sequencer: RTL

//  Control FSM for one single-MAC fully-connected layer datapath: x memory, W ROM, B ROM, MAC and y memory.

---
 rtl/layer_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// Control FSM for a single-MAC fully-connected layer: loads x, sequences M bias+dot-product rows, streams y.
// Addresses/enables only; all arithmetic and memories live in the surrounding datapath.
module layer_sequencer #(
  parameter int N    = 8,
  parameter int M    = 6,
  parameter int LOGN = 3,
  parameter int LOGM = 3,
  parameter int LOGW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [LOGN-1:0] addr_x,
  output logic            wr_en_x,
  output logic [LOGW-1:0] addr_w,
  output logic [LOGM-1:0] addr_b,
  output logic            ld_bias,
  output logic            en_mac,
  output logic [LOGM-1:0] addr_y,
  output logic            wr_en_y
);

  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(N + 3);
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  localparam logic [KW-1:0] K_LAST    = KW'(N - 1);
  localparam logic [KW-1:0] K_SAT     = KW'(N);
  localparam logic [CW-1:0] C_NCOLS   = CW'(N);
  localparam logic [CW-1:0] C_BIAS    = CW'(1);
  localparam logic [CW-1:0] C_MAC_BEG = CW'(2);
  localparam logic [CW-1:0] C_MAC_END = CW'(N + 1);
  localparam logic [CW-1:0] C_LAST    = CW'(N + 2);
  localparam logic [RW-1:0] R_LAST    = RW'(M - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    COMP = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [CW-1:0]   c;
  logic [RW-1:0]   r;
  logic [RW-1:0]   i;
  logic            primed;

  // Last driven address values, replayed whenever a state does not own that address.
  logic [LOGN-1:0] hold_x;
  logic [LOGW-1:0] hold_w;
  logic [LOGM-1:0] hold_b;
  logic [LOGM-1:0] hold_y;

  logic [LOGN-1:0] col;
  logic [LOGW-1:0] w_idx;
  logic            fire;

  always_comb begin
    col   = (c < C_NCOLS) ? LOGN'(c) : LOGN'(N - 1);
    w_idx = LOGW'(r) * LOGW'(N) + LOGW'(col);
  end

  assign fire = (state == OUT) && primed && m_ready;

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    wr_en_x = 1'b0;
    ld_bias = 1'b0;
    en_mac  = 1'b0;
    wr_en_y = 1'b0;
    addr_x  = hold_x;
    addr_w  = hold_w;
    addr_b  = hold_b;
    addr_y  = hold_y;
    if (!reset) begin
      addr_x = '0;
      addr_w = '0;
      addr_b = '0;
      addr_y = '0;
    end else begin
      case (state)
        LOAD: begin
          s_ready = 1'b1;
          wr_en_x = s_valid;
          addr_x  = LOGN'(k);
        end
        COMP: begin
          addr_x  = col;
          addr_w  = w_idx;
          addr_b  = LOGM'(r);
          ld_bias = (c == C_BIAS);
          en_mac  = (c >= C_MAC_BEG) && (c <= C_MAC_END);
          if (c == C_LAST) begin
            wr_en_y = 1'b1;
            addr_y  = LOGM'(r);
          end
        end
        OUT: begin
          m_valid = primed;
          // Look one word ahead on a fire so the sync-read y memory can stream back-to-back.
          addr_y  = fire ? LOGM'(i) + LOGM'(1) : LOGM'(i);
        end
        default: begin
          s_ready = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= LOAD;
      k      <= '0;
      c      <= '0;
      r      <= '0;
      i      <= '0;
      primed <= 1'b0;
      hold_x <= '0;
      hold_w <= '0;
      hold_b <= '0;
      hold_y <= '0;
    end else begin
      hold_x <= addr_x;
      hold_w <= addr_w;
      hold_b <= addr_b;
      hold_y <= addr_y;
      case (state)
        LOAD: begin
          if (s_valid) begin
            if (k != K_SAT) k <= k + KW'(1);
            if (k == K_LAST) begin
              state <= COMP;
              c     <= '0;
              r     <= '0;
            end
          end
        end
        COMP: begin
          if (c == C_LAST) begin
            if (r == R_LAST) begin
              state  <= OUT;
              i      <= '0;
              primed <= 1'b0;
            end else begin
              r <= r + RW'(1);
              c <= '0;
            end
          end else begin
            c <= c + CW'(1);
          end
        end
        OUT: begin
          primed <= 1'b1;
          if (fire) begin
            if (i == R_LAST) begin
              state  <= LOAD;
              k      <= '0;
              primed <= 1'b0;
            end else begin
              i <= i + RW'(1);
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
